// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared types and helpers for the LED fade/PWM output stage.
// Provides the default brightness resolution, the level type and the gamma-2
// duty mapping used when LED_FADE_GAMMA_EN is defined.
package led_fade_pkg;

  localparam int PWM_BITS_DEF = 8;
  // Working width for the gamma helper; supports PWM_BITS up to 16.
  localparam int GAMMA_W      = 16;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

  // Squared-law brightness: (level*(level+1)) >> bits, computed at double
  // width. The +1 keeps the full-scale endpoint at full scale.
  function automatic logic [GAMMA_W-1:0] gamma2(input logic [GAMMA_W-1:0] level,
                                                input int unsigned        bits);
    logic [2*GAMMA_W-1:0] ext;
    logic [2*GAMMA_W-1:0] prod;
    ext  = {{GAMMA_W{1'b0}}, level};
    prod = ext * (ext + 32'd1);
    return GAMMA_W'(prod >> bits);
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED channel - brightness level register that steps by
// one toward target on each tick, plus the registered PWM duty compare.
// Ports: clk/resetn, tick, pwm_cnt, target, enable in; led_out, mismatch out.
// Macro LED_FADE_GAMMA_EN selects gamma-2 duty mapping; default is linear.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] target,
  input  logic                enable,
  output logic                led_out,
  output logic                mismatch
);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_nxt;
  logic [PWM_BITS-1:0] duty;

  // Single step per tick toward the live target; the compare itself keeps the
  // level inside 0..max so no wrap can occur.
  always_comb begin
    level_nxt = level;
    if (tick) begin
      if (level < target) begin
        level_nxt = level + PWM_BITS'(1);
      end else if (level > target) begin
        level_nxt = level - PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
    end else begin
      level <= level_nxt;
    end
  end

`ifdef LED_FADE_GAMMA_EN
  assign duty = PWM_BITS'(gamma2(GAMMA_W'(level), PWM_BITS));
`else
  assign duty = level;
`endif

  // pwm_cnt never reaches all-ones, so full-scale duty is on every cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_out <= 1'b0;
    end else begin
      led_out <= enable & (duty > pwm_cnt);
    end
  end

  assign mismatch = (level != target);

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: PWM LED driver that fades each channel linearly toward its
// commanded brightness (led_in bit ? max_level : 0).
// Ports: clk, resetn (async, active-low), led_in, enable, max_level in;
// led_out (registered PWM pins), busy (registered, any channel still ramping).
// Macro LED_FADE_GAMMA_EN (in led_fade_channel) enables gamma-2 duty mapping.
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int N_LEDS   = 4,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int RAMP_DIV = 12900
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_LEDS-1:0]   led_in,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] max_level,
  output logic [N_LEDS-1:0]   led_out,
  output logic                busy
);

  localparam int                RC_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RAMP_DIV - 1);
  // Period of 2**PWM_BITS-1 clocks: counter stops one short of all-ones.
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [RC_W-1:0]     ramp_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_LEDS-1:0]   led_in_q;
  logic [N_LEDS-1:0]   mismatch;
  logic [PWM_BITS-1:0] target [N_LEDS];

  // With RAMP_DIV=1 the counter sits at 0 and tick is constantly high.
  assign tick = (ramp_cnt == RC_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ramp_cnt <= '0;
    end else if (tick) begin
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= ramp_cnt + RC_W'(1);
    end
  end

  // Free-running; enable only gates the output pins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == PWM_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_in_q <= '0;
    end else begin
      led_in_q <= led_in;
    end
  end

  // max_level feeds the target combinationally so a change steps on the
  // very next tick.
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      target[i] = led_in_q[i] ? max_level : '0;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .tick     (tick),
      .pwm_cnt  (pwm_cnt),
      .target   (target[i]),
      .enable   (enable),
      .led_out  (led_out[i]),
      .mismatch (mismatch[i])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
    end else begin
      busy <= |mismatch;
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: directed bench for led_fade_pwm with PWM_BITS=4, RAMP_DIV=4
// (15-clock PWM period, tick every 4th clock after reset release).
// Inputs change on the falling edge; outputs are sampled there too.
`timescale 1ns/1ps
module tb_led_fade_pwm;

  localparam int N  = 4;
  localparam int PB = 4;
  localparam int RD = 4;

`ifdef LED_FADE_GAMMA_EN
  localparam int DUTY8 = 4;  // (8*9)>>4
  localparam int DUTY4 = 1;  // (4*5)>>4
`else
  localparam int DUTY8 = 8;
  localparam int DUTY4 = 4;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [N-1:0]  led_in = '0;
  logic          enable = 1'b0;
  logic [PB-1:0] max_level = '0;
  logic [N-1:0]  led_out;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int hi [N];

  led_fade_pwm #(
    .N_LEDS   (N),
    .PWM_BITS (PB),
    .RAMP_DIV (RD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .led_in    (led_in),
    .enable    (enable),
    .max_level (max_level),
    .led_out   (led_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each step lands on the falling edge after one more rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic int lvl0();
    return int'(dut.g_ch[0].u_ch.level);
  endfunction

  // Any 15 consecutive samples cover exactly one PWM period.
  task automatic measure_window();
    for (int b = 0; b < N; b++) hi[b] = 0;
    for (int s = 0; s < 15; s++) begin
      step(1);
      for (int b = 0; b < N; b++) hi[b] += int'(led_out[b]);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    step(2);
    for (int i = 0; i < budget && busy; i++) step(1);
    check_eq(tag, busy, 0);
  endtask

  task automatic wait_level(input int lvl, input int budget, input string tag);
    for (int i = 0; i < budget && lvl0() != lvl; i++) step(1);
    check_eq(tag, lvl0(), lvl);
  endtask

  initial begin
    int cnt;
    logic [N-1:0] acc;

    // 1. Reset / bring-up
    led_in    = 4'hF;
    enable    = 1'b1;
    max_level = 4'd15;
    #1 resetn = 1'b0;
    #1;
    check_eq("rst_led_out", led_out, 0);
    check_eq("rst_busy", busy, 0);
    step(3);
    resetn = 1'b1;
    cyc    = 0;
    step(1);
    check_eq("busy_p1", busy, 0);
    step(1);
    check_eq("busy_rise", busy, 1);
    step(58);
    check_eq("busy_last_tick", busy, 1);
    step(1);
    check_eq("busy_fall", busy, 0);
    measure_window();
    for (int b = 0; b < N; b++) check_eq("full_on", hi[b], 15);

    // 2. Duty check
    led_in    = 4'b0001;
    max_level = 4'd8;
    wait_idle(100, "t2_settle");
    measure_window();
    check_eq("t2_duty0", hi[0], DUTY8);
    for (int b = 1; b < N; b++) check_eq("t2_off", hi[b], 0);

    // 3. Reversal mid-ramp at level 6
    led_in = 4'b0000;
    wait_idle(100, "t3_settle_lo");
    led_in    = 4'b0001;
    max_level = 4'd15;
    wait_level(6, 60, "t3_reach6");
    led_in = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      step(4);
      check_eq("t3_ramp_down", lvl0(), 6 - k);
    end
    check_eq("t3_busy_hold", busy, 1);
    step(1);
    check_eq("t3_busy_fall", busy, 0);

    // 4. Target change 15 -> 4, aligned just after a tick edge
    led_in    = 4'hF;
    max_level = 4'd15;
    wait_idle(100, "t4_settle_hi");
    while (cyc % 4 != 0) step(1);
    max_level = 4'd4;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      cnt += int'(busy);
    end
    check_eq("t4_busy_cycles", cnt, 44);
    measure_window();
    for (int b = 0; b < N; b++) check_eq("t4_duty", hi[b], DUTY4);

    // 5. Enable gating during a ramp
    max_level = 4'd15;
    step(6);
    enable = 1'b0;
    step(1);
    check_eq("t5_gate", led_out, 0);
    check_eq("t5_busy", busy, 1);
    acc = '0;
    for (int i = 0; i < 100 && busy; i++) begin
      step(1);
      acc |= led_out;
    end
    check_eq("t5_settle", busy, 0);
    check_eq("t5_dark", acc, 0);
    enable = 1'b1;
    step(1);
    check_eq("t5_resume", led_out, 4'hF);

    // 6. Async reset mid-ramp around level 9
    led_in = 4'h0;
    wait_idle(100, "t6_settle_lo");
    led_in = 4'hF;
    wait_level(9, 80, "t6_reach9");
    for (int i = 0; i < 20 && !led_out[0]; i++) step(1);
    check_eq("t6_lit", led_out[0], 1);
    #2 resetn = 1'b0;
    #1;
    check_eq("t6_async", led_out, 0);
    check_eq("t6_lvl_rst", lvl0(), 0);
    step(2);
    resetn = 1'b1;
    cyc    = 0;
    step(3);
    check_eq("t6_restart0", lvl0(), 0);
    step(1);
    check_eq("t6_restart1", lvl0(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
